// File: rtl/captura_contador.sv
// Event capture for a 3-bit upstream counter: every change of q_in is queued in a FWFT FIFO.
// Optional CAPTURA_TIMESTAMP_EN appends a saturating edges-since-last-event timestamp to each entry.
module captura_contador #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8,
`ifdef CAPTURA_TIMESTAMP_EN
  localparam int unsigned EW = 3 + TS_W
`else
  localparam int unsigned EW = 3
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    q_in,
  input  logic          rd_en,
  output logic [EW-1:0] dout,
  output logic          valid,
  output logic          overflow,
  output logic          seq_err,
  output logic [7:0]    wrap_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [2:0]    q_prev_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          seq_err_q, seq_err_d;
  logic [7:0]    wrap_q, wrap_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          evt, full, pop, push;
  logic [2:0]    q_expect;
  logic [EW-1:0] entry;

`ifdef CAPTURA_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d, ts_push;

  always_comb begin
    ts_push = (ts_q == '1) ? ts_q : ts_q + 1'b1;
    ts_d    = evt ? '0 : ts_push;
    entry   = {q_in, ts_push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_d;
  end
`else
  always_comb entry = q_in;
`endif

  // A push into a full FIFO is accepted only when the head leaves on the same edge.
  always_comb begin
    evt        = (q_in != q_prev_q);
    q_expect   = q_prev_q + 3'd1;
    valid      = (count_q != '0);
    full       = (count_q == CW'(DEPTH));
    pop        = rd_en && valid;
    push       = evt && (!full || pop);
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
    overflow_d = overflow_q || (evt && full && !pop);
    seq_err_d  = seq_err_q  || (evt && (q_in != q_expect));
    wrap_d     = (evt && q_prev_q == 3'd7 && q_in == 3'd0) ? wrap_q + 1'b1 : wrap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_prev_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
      wrap_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      q_prev_q   <= q_in;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
      wrap_q     <= wrap_d;
      if (push) mem_q[wr_ptr_q] <= entry;
    end
  end

  assign dout       = mem_q[rd_ptr_q];
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;
  assign wrap_count = wrap_q;

endmodule

// File: tb/tb_captura_contador.sv
// Directed bench for captura_contador; timestamp expectations follow CAPTURA_TIMESTAMP_EN.
module tb_captura_contador;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TS_W  = 8;
`ifdef CAPTURA_TIMESTAMP_EN
  localparam int unsigned EW = 3 + TS_W;
`else
  localparam int unsigned EW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_en = 1'b0;
  logic [2:0]    q_in = 3'd0;
  logic [EW-1:0] dout;
  logic          valid, overflow, seq_err;
  logic [7:0]    wrap_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  captura_contador #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .rd_en(rd_en), .dout(dout),
    .valid(valid), .overflow(overflow), .seq_err(seq_err), .wrap_count(wrap_count)
  );

  function automatic logic [EW-1:0] ent(input logic [2:0] s, input int unsigned ts);
`ifdef CAPTURA_TIMESTAMP_EN
    return {s, TS_W'(ts)};
`else
    return s;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; q_in = 3'd0; rd_en = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    n_vec++; if (wrap_count !== 8'd0) begin n_err++; $display("FAIL reset_wrap: got %0d want 0", wrap_count); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_empty_pop();
    rd_en = 1'b1;
    step(); step();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL empty_pop_valid: got %b want 0", valid); end
    q_in = 3'd1;
    step();
    rd_en = 1'b0;
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL empty_push_valid: got %b want 1", valid); end
    n_vec++; if (dout[EW-1 -: 3] !== 3'd1) begin n_err++; $display("FAIL empty_push_state: got %0d want 1", dout[EW-1 -: 3]); end
  endtask

  task automatic test_basic();
    do_reset();
    q_in = 3'd1; step();
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", valid); end
    n_vec++; if (dout !== ent(3'd1, 1)) begin n_err++; $display("FAIL basic_head1: got %h want %h", dout, ent(3'd1, 1)); end
    q_in = 3'd2; step();
    n_vec++; if (dout !== ent(3'd1, 1)) begin n_err++; $display("FAIL basic_head_hold: got %h want %h", dout, ent(3'd1, 1)); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL basic_seq_err: got %b want 0", seq_err); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_vec++; if (dout !== ent(3'd2, 1)) begin n_err++; $display("FAIL basic_head2: got %h want %h", dout, ent(3'd2, 1)); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", valid); end
  endtask

  // Continues from test_basic: two steady edges since the q_in=2 event.
  task automatic test_timestamp();
    q_in = 3'd3; step();
    n_vec++; if (dout !== ent(3'd3, 3)) begin n_err++; $display("FAIL ts_three: got %h want %h", dout, ent(3'd3, 3)); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    repeat (4) step();
    q_in = 3'd4; step();
    n_vec++; if (dout !== ent(3'd4, 6)) begin n_err++; $display("FAIL ts_six: got %h want %h", dout, ent(3'd4, 6)); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    repeat (300) step();
    q_in = 3'd5; step();
    n_vec++; if (dout !== ent(3'd5, 255)) begin n_err++; $display("FAIL ts_saturate: got %h want %h", dout, ent(3'd5, 255)); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ts_drain: got %b want 0", valid); end
  endtask

  task automatic test_overflow_wrap();
    logic [2:0] seq [5];
    seq = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    do_reset();
    for (int i = 1; i <= 4; i++) begin q_in = 3'(i); step(); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at_full: got %b want 0", overflow); end
    for (int i = 0; i < 5; i++) begin q_in = seq[i]; step(); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", overflow); end
    n_vec++; if (wrap_count !== 8'd1) begin n_err++; $display("FAIL ovf_wrap: got %0d want 1", wrap_count); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL ovf_seq_err: got %b want 0", seq_err); end
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if (dout !== ent(3'(i), 1)) begin n_err++; $display("FAIL ovf_entry%0d: got %h want %h", i, dout, ent(3'(i), 1)); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %b want 0", valid); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) begin q_in = 3'(i); step(); end
    q_in = 3'd5; rd_en = 1'b1; step(); rd_en = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
    for (int i = 2; i <= 5; i++) begin
      n_vec++; if (dout !== ent(3'(i), 1) || valid !== 1'b1) begin n_err++; $display("FAIL b2b_entry%0d: got %h/%b want %h/1", i, dout, valid, ent(3'(i), 1)); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", valid); end
  endtask

  task automatic test_seq_err_async_reset();
    do_reset();
    q_in = 3'd1; step();
    q_in = 3'd2; step();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL seq_before_jump: got %b want 0", seq_err); end
    q_in = 3'd5; step();
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_jump: got %b want 1", seq_err); end
    rd_en = 1'b1; step(); step(); rd_en = 1'b0;
    n_vec++; if (dout !== ent(3'd5, 1)) begin n_err++; $display("FAIL seq_entry5: got %h want %h", dout, ent(3'd5, 1)); end
    q_in = 3'd6; step(); q_in = 3'd7; step(); q_in = 3'd0; step();
    n_vec++; if (wrap_count !== 8'd1) begin n_err++; $display("FAIL seq_wrap: got %0d want 1", wrap_count); end
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL seq_sticky: got %b want 1", seq_err); end
    #2; rst_n = 1'b0; #1;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", valid); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL async_seq_err: got %b want 0", seq_err); end
    n_vec++; if (wrap_count !== 8'd0) begin n_err++; $display("FAIL async_wrap: got %0d want 0", wrap_count); end
    #1; rst_n = 1'b1;
    step();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL post_reset_no_event: got %b want 0", valid); end
  endtask

  task automatic test_wrap_rollover();
    do_reset();
    repeat (255) for (int s = 1; s <= 8; s++) begin q_in = 3'(s); step(); end
    n_vec++; if (wrap_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", wrap_count); end
    for (int s = 1; s <= 8; s++) begin q_in = 3'(s); step(); end
    n_vec++; if (wrap_count !== 8'd0) begin n_err++; $display("FAIL wrap_roll: got %0d want 0", wrap_count); end
  endtask

  initial begin
    test_reset();
    test_empty_pop();
    test_basic();
    test_timestamp();
    test_overflow_wrap();
    test_back_to_back();
    test_seq_err_async_reset();
    test_wrap_rollover();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
